// File: rtl/zeroriscy_data_mem_responder.sv
// Data-bus responder: req/gnt/rvalid/err slave in front of a byte-enabled word RAM.
// Ports: clk/rst_n, data_* bus (req,gnt,rvalid,err,addr,we,be,wdata,rdata), gnt_stall_i, busy_o.
module zeroriscy_data_mem_responder #(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned GNT_DELAY    = 0,
  parameter int unsigned RVALID_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  input  logic        gnt_stall_i,
  output logic        busy_o
);

  localparam int unsigned IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + 33'(MEM_WORDS) * 33'd4;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] gcnt;
  logic [31:0] gcnt_nxt;
  logic [31:0] dcnt;
  logic [31:0] dcnt_nxt;
  logic        resp_err;
  logic        resp_err_nxt;
  logic [31:0] resp_rdata;
  logic [31:0] resp_rdata_nxt;

  logic        gnt;
  logic        rvalid_now;
  logic [32:0] word_addr;
  logic        in_range;
  logic [IW-1:0] idx;
  logic [31:0] rd_word;
  logic        unused_addr;

  logic [31:0] mem [MEM_WORDS];

  // Base is aligned to the array size, so the low
  // address bits are the word index directly.
  assign word_addr   = {1'b0, data_addr_i[31:2], 2'b00};
  assign in_range    = (word_addr >= LO) && (word_addr < HI);
  assign idx         = data_addr_i[IW+1:2];
  assign rd_word     = mem[idx];
  assign unused_addr = ^data_addr_i[1:0];

  assign rvalid_now = (state == RESP) && (dcnt == 32'd0);

  // A new request may be granted in the cycle the
  // previous response returns (no bubble).
  assign gnt = data_req_i && !gnt_stall_i
            && (gcnt >= 32'(GNT_DELAY))
            && ((state == IDLE) || rvalid_now);

  always_comb begin
    state_nxt      = state;
    dcnt_nxt       = dcnt;
    gcnt_nxt       = 32'd0;
    resp_err_nxt   = resp_err;
    resp_rdata_nxt = resp_rdata;

    if (data_req_i && !gnt) begin
      gcnt_nxt = (gcnt == 32'hFFFF_FFFF) ? gcnt : gcnt + 32'd1;
    end

    unique case (state)
      IDLE: begin
        if (gnt) begin
          state_nxt = RESP;
          dcnt_nxt  = 32'(RVALID_DELAY);
        end
      end
      RESP: begin
        if (dcnt != 32'd0) begin
          dcnt_nxt = dcnt - 32'd1;
        end else if (gnt) begin
          state_nxt = RESP;
          dcnt_nxt  = 32'(RVALID_DELAY);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (gnt) begin
      resp_err_nxt   = !in_range;
      resp_rdata_nxt = (in_range && !data_we_i) ? rd_word : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gcnt       <= 32'd0;
      dcnt       <= 32'd0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state      <= state_nxt;
      gcnt       <= gcnt_nxt;
      dcnt       <= dcnt_nxt;
      resp_err   <= resp_err_nxt;
      resp_rdata <= resp_rdata_nxt;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (gnt && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_now;
  assign data_err_o    = rvalid_now && resp_err;
  assign data_rdata_o  = rvalid_now ? resp_rdata : 32'd0;
  assign busy_o        = (state == RESP);

endmodule
